dpram_clr: RTL
==============

# dpram_clr

Single-clock, parametrised dual-port block RAM with per-lane byte enables, selectable read-during-write behaviour, deterministic same-address write arbitration, an optional output pipeline stage and a built-in clear sequencer. The sequencer fills the whole array with a constant after reset or on request. It is the next-generation video/work RAM primitive for arcade cores that need a known power-up state, such as sprite, palette or character RAM. The RAM contents are never reset by `reset_n`; they are only rewritten by the clear sequencer.

## Interface
Parameters:
- `addr_width_g`, 8: address bits; depth is 2**addr_width_g words.
- `data_width_g`, 8: word width; must be a multiple of `lane_width_g`.
- `lane_width_g`, 8: bits per byte-enable lane; LANES = data_width_g/lane_width_g.
- `rdw_mode_g`, 0: same-port read-during-write. 0 = old data, 1 = new (merged) data.
- `out_reg_g`, 0: 1 adds an output register stage to q_a/q_b.
- `clear_on_reset_g`, 1: 1 starts a clear sweep automatically when reset releases.
- `clear_value_g`, 0: fill value written per word, `data_width_g` bits.

Ports:
- `clock`, in, 1: the only clock; all logic on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `clear_req`, in, 1: single-cycle pulse that starts a clear sweep.
- `busy`, out, 1: high while the clear sweep runs.
- `enable_a`, `enable_b`, in, 1 each: port access enable.
- `wren_a`, `wren_b`, in, 1 each: write enable, qualified by the matching enable.
- `byteena_a`, `byteena_b`, in, LANES each: lane write mask.
- `address_a`, `address_b`, in, addr_width_g each: word address.
- `data_a`, `data_b`, in, data_width_g each: write data.
- `q_a`, `q_b`, out, data_width_g each: read data.

## Operation
- FSM states are IDLE and CLEAR.
  - While reset is asserted: state = CLEAR if clear_on_reset_g else IDLE; clear counter = 0.
  - IDLE -> CLEAR when clear_req=1.
  - In CLEAR, write clear_value_g to address counter each cycle, then increment the counter.
  - CLEAR -> IDLE in the cycle the counter writes address 2**addr_width_g-1; the counter returns to 0.
- busy = (state == CLEAR).
- While busy:
  - enable_a/enable_b are ignored (no write, no read).
  - q_a/q_b hold their values.
  - clear_req is ignored; a sweep is never restarted or extended.
- Write (IDLE, enable_x & wren_x): lane i of word address_x gets data_x lane i where byteena_x[i]=1; other lanes keep their value.
- Read (IDLE, enable_x): the read stage loads word address_x; wren_x does not suppress the read.
- Same-port read-during-write:
  - rdw_mode_g=0: the read returns the pre-write word.
  - rdw_mode_g=1: the read returns the merged word (new lanes plus untouched old lanes).
- Cross-port read of an address written the same cycle by the other port always returns the old word.
- Both ports write the same address in the same cycle: per lane, port A wins where byteena_a[i]=1; port B writes only lanes with byteena_b[i]=1 and byteena_a[i]=0.
- Ports with enable low: q holds, no write.

## Timing
- Reset values: q_a = q_b = 0, output pipeline registers = 0, busy = clear_on_reset_g.
- Read latency: 1 clock for out_reg_g=0, 2 clocks for out_reg_g=1.
- The out_reg_g stage loads only when the previous-cycle enable was accepted (delayed enable flag), so q holds across idle cycles.
- Clear sweep length is exactly 2**addr_width_g cycles. busy is high for that many rising edges starting from the edge that samples clear_req (or from reset release), and falls after the edge that writes the last address.
- A read issued in the first IDLE cycle after busy falls returns clear_value_g.
- reset_n asserted mid-sweep: FSM, counter, q and pipeline registers reset immediately and asynchronously. Partially cleared RAM is undefined until the next sweep, which restarts at address 0 if clear_on_reset_g=1.
- Writes and reads take effect at the rising edge on which enable_x is high; there is no handshake beyond busy.

## Test plan
- Defaults, reset release: busy stays high 256 cycles. Then a read of every address from A and B returns 0x00. q_a = q_b = 0 throughout reset.
- data_width_g=16, lane_width_g=8: write 0xABCD to addr 5, then write 0x12 with byteena_a=2'b01 -> a read of addr 5 returns 0xAB12.
- rdw_mode_g=0: write 0x55 to addr 3 (old 0x11) with a same-cycle read on A returns 0x11. With rdw_mode_g=1 the same access returns 0x55. A cross-port B read of addr 3 in that cycle returns 0x11 in both modes.
- Collision: A writes 0x11AA with byteena=2'b01 and B writes 0x2233 with byteena=2'b11 to addr 9, both old 0x0000 -> addr 9 reads 0x22AA.
- out_reg_g=1: a read of addr 7 holding 0x3C returns the value on the second edge. With enable low, q holds 0x3C indefinitely.
- Two mid-sweep events:
  - clear_req mid-sweep: ignored; busy still falls at 256 cycles.
  - reset_n pulsed at counter=100: busy stays high with counter at 0, then a full 256-cycle sweep runs after release.

Source files
------------

// File: rtl/dpram_clr.sv
// dpram_clr
// Single-clock dual-port RAM with per-lane byte enables, a selectable
// same-port read-during-write mode, and deterministic same-address write
// arbitration in which port A wins per lane. It has an optional output
// register and a clear sequencer that fills the array with clear_value_g
// after reset or on request. The array contents themselves are never reset.
//
// Ports:
//   clock                 rising-edge clock for all logic
//   reset_n               asynchronous active-low reset (control, q, pipeline)
//   clear_req             one-cycle pulse starting a clear sweep (ignored while busy)
//   busy                  high while the clear sweep runs
//   enable_a/b            port access enable (ignored while busy)
//   wren_a/b              write enable, qualified by enable
//   byteena_a/b [LANES]   lane write mask
//   address_a/b           word address
//   data_a/b              write data
//   q_a/b                 read data (1 or 2 clocks latency)
module dpram_clr #(
  parameter int addr_width_g     = 8,
  parameter int data_width_g     = 8,
  parameter int lane_width_g     = 8,
  parameter int rdw_mode_g       = 0,
  parameter int out_reg_g        = 0,
  parameter int clear_on_reset_g = 1,
  parameter logic [data_width_g-1:0] clear_value_g = '0,
  localparam int LANES = data_width_g / lane_width_g
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clear_req,
  output logic                    busy,
  input  logic                    enable_a,
  input  logic                    enable_b,
  input  logic                    wren_a,
  input  logic                    wren_b,
  input  logic [LANES-1:0]        byteena_a,
  input  logic [LANES-1:0]        byteena_b,
  input  logic [addr_width_g-1:0] address_a,
  input  logic [addr_width_g-1:0] address_b,
  input  logic [data_width_g-1:0] data_a,
  input  logic [data_width_g-1:0] data_b,
  output logic [data_width_g-1:0] q_a,
  output logic [data_width_g-1:0] q_b
);

  localparam int DEPTH = 1 << addr_width_g;
  localparam int LW    = lane_width_g;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [0:0] ST_RESET = (clear_on_reset_g != 0) ? ST_CLEAR : ST_IDLE;

  logic [data_width_g-1:0] r_mem [DEPTH];

  logic [0:0]              r_state;
  logic [addr_width_g-1:0] r_cnt;
  logic [data_width_g-1:0] r_q_a;
  logic [data_width_g-1:0] r_q_b;

  logic                    w_busy;
  logic                    w_acc_a;
  logic                    w_acc_b;
  logic                    w_we_a;
  logic                    w_we_b;
  logic                    w_same_addr;
  logic [data_width_g-1:0] w_old_a;
  logic [data_width_g-1:0] w_old_b;
  logic [data_width_g-1:0] w_mrg_a;
  logic [data_width_g-1:0] w_mrg_b;

  assign w_busy      = (r_state == ST_CLEAR);
  assign busy        = w_busy;
  assign w_acc_a     = enable_a & ~w_busy;
  assign w_acc_b     = enable_b & ~w_busy;
  assign w_we_a      = w_acc_a & wren_a;
  assign w_we_b      = w_acc_b & wren_b;
  assign w_same_addr = (address_a == address_b);

  // Clear sequencer: one word per cycle, leaves CLEAR on the last address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RESET;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clear_req) r_state <= ST_CLEAR;
        end
        default: begin
          if (r_cnt == '1) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Array writes. Port B lanes are written first and port A afterwards, and
  // B additionally skips lanes A owns on a shared address, so A always wins.
  always_ff @(posedge clock) begin
    if (w_busy) begin
      r_mem[r_cnt] <= clear_value_g;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (w_we_b && byteena_b[i] && !(w_we_a && byteena_a[i] && w_same_addr))
          r_mem[address_b][i*LW +: LW] <= data_b[i*LW +: LW];
        if (w_we_a && byteena_a[i])
          r_mem[address_a][i*LW +: LW] <= data_a[i*LW +: LW];
      end
    end
  end

  // Old word and own-port merged word. The merge ignores the other port, so
  // a cross-port read of a word written this cycle always sees the old data.
  always_comb begin
    w_old_a = r_mem[address_a];
    w_old_b = r_mem[address_b];
    w_mrg_a = w_old_a;
    w_mrg_b = w_old_b;
    for (int i = 0; i < LANES; i++) begin
      if (wren_a && byteena_a[i]) w_mrg_a[i*LW +: LW] = data_a[i*LW +: LW];
      if (wren_b && byteena_b[i]) w_mrg_b[i*LW +: LW] = data_b[i*LW +: LW];
    end
  end

  // Read stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q_a <= '0;
      r_q_b <= '0;
    end else begin
      if (w_acc_a) r_q_a <= (rdw_mode_g == 1) ? w_mrg_a : w_old_a;
      if (w_acc_b) r_q_b <= (rdw_mode_g == 1) ? w_mrg_b : w_old_b;
    end
  end

  // Optional output stage, loaded only behind an accepted access so q holds
  // across idle cycles.
  generate
    if (out_reg_g != 0) begin : g_oreg
      logic                    r_vld_a;
      logic                    r_vld_b;
      logic [data_width_g-1:0] r_q2_a;
      logic [data_width_g-1:0] r_q2_b;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_vld_a <= 1'b0;
          r_vld_b <= 1'b0;
          r_q2_a  <= '0;
          r_q2_b  <= '0;
        end else begin
          r_vld_a <= w_acc_a;
          r_vld_b <= w_acc_b;
          if (r_vld_a) r_q2_a <= r_q_a;
          if (r_vld_b) r_q2_b <= r_q_b;
        end
      end

      assign q_a = r_q2_a;
      assign q_b = r_q2_b;
    end else begin : g_noreg
      assign q_a = r_q_a;
      assign q_b = r_q_b;
    end
  endgenerate

endmodule
